// File: rtl/trap_controller_pkg.sv
// Shared types, widths and defaults for the machine-mode trap controller.
package trap_controller_pkg;

  localparam int XLEN        = 32;
  localparam int CAUSE_WIDTH = 4;

  localparam logic [CAUSE_WIDTH-1:0] IRQ_CAUSE_DEF      = 4'd11;
  localparam int                     RECOVER_CYCLES_DEF = 1;

  typedef enum logic [CAUSE_WIDTH-1:0] {
    INSTR_MISALIGNED = 4'd0,
    ILLEGAL_INSTR    = 4'd2,
    BREAKPOINT       = 4'd3,
    LOAD_MISALIGNED  = 4'd4,
    STORE_MISALIGNED = 4'd6,
    ECALL_M          = 4'd11
  } trap_cause_e;

  typedef struct packed {
    logic                   valid;
    logic [CAUSE_WIDTH-1:0] cause;
    logic [XLEN-1:0]        tval;
  } pending_trap_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } trap_state_e;

  localparam pending_trap_t NO_PENDING = '0;

  // Invalid raises collapse to an all-zero record so stale cause/tval never travel.
  function automatic pending_trap_t make_pending(input logic                   valid,
                                                 input logic [CAUSE_WIDTH-1:0] cause,
                                                 input logic [XLEN-1:0]        tval);
    pending_trap_t rec;
    rec = NO_PENDING;
    if (valid) begin
      rec.valid = 1'b1;
      rec.cause = cause;
      rec.tval  = tval;
    end else begin
      rec = NO_PENDING;
    end
    return rec;
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Pipeline/CSR-file side signals of the trap controller; master drives the pipeline view.
interface trap_controller_if;
  import trap_controller_pkg::*;

  logic                   decodeTrap;
  logic [CAUSE_WIDTH-1:0] decodeCause;
  logic [XLEN-1:0]        decodeTval;
  logic                   executeTrap;
  logic [CAUSE_WIDTH-1:0] executeCause;
  logic [XLEN-1:0]        executeTval;
  logic                   memoryTrap;
  logic [CAUSE_WIDTH-1:0] memoryCause;
  logic [XLEN-1:0]        memoryTval;
  logic                   advanceDE;
  logic                   advanceEM;
  logic                   advanceMW;
  logic                   writebackValid;
  logic                   writebackMret;
  logic                   interrupt;
  logic                   mie;
  logic [XLEN-1:0]        trapVector;
  logic [XLEN-1:0]        mepc;

  logic                   controlReset;
  logic [CAUSE_WIDTH-1:0] mcause;
  logic                   mcauseInterrupt;
  logic [XLEN-1:0]        mtval;
  logic                   mretSignal;
  logic                   retireValid;
  logic                   flush;
  logic                   redirectValid;
  logic [XLEN-1:0]        redirectPC;

  modport master (
    output decodeTrap, decodeCause, decodeTval,
    output executeTrap, executeCause, executeTval,
    output memoryTrap, memoryCause, memoryTval,
    output advanceDE, advanceEM, advanceMW,
    output writebackValid, writebackMret, interrupt, mie, trapVector, mepc,
    input  controlReset, mcause, mcauseInterrupt, mtval, mretSignal,
    input  retireValid, flush, redirectValid, redirectPC
  );

  modport slave (
    input  decodeTrap, decodeCause, decodeTval,
    input  executeTrap, executeCause, executeTval,
    input  memoryTrap, memoryCause, memoryTval,
    input  advanceDE, advanceEM, advanceMW,
    input  writebackValid, writebackMret, interrupt, mie, trapVector, mepc,
    output controlReset, mcause, mcauseInterrupt, mtval, mretSignal,
    output retireValid, flush, redirectValid, redirectPC
  );

endinterface

// File: rtl/trap_controller_pending_stage.sv
// One per-stage pending exception record: capture on advance, oldest-wins merge,
// in-place absorb while stalled, bubble clear and flush clear.
module trap_pending_stage
  import trap_controller_pkg::*;
(
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          advance_in_i,
  input  logic          advance_out_i,
  input  pending_trap_t upstream_i,
  input  pending_trap_t upstream_raise_i,
  input  pending_trap_t local_raise_i,
  output pending_trap_t pend_o
);

  pending_trap_t pend_q;
  pending_trap_t pend_d;

  // A carried record always beats a raise from a younger stage of the same instruction.
  always_comb begin
    pend_d = pend_q;
    if (clear_i) begin
      pend_d = NO_PENDING;
    end else if (advance_in_i) begin
      pend_d = upstream_i.valid ? upstream_i : upstream_raise_i;
    end else if (advance_out_i) begin
      pend_d = NO_PENDING;
    end else if (!pend_q.valid) begin
      pend_d = local_raise_i;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pend_q <= NO_PENDING;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap/MRET commit controller: carries per-stage exception records to
// writeback and issues the CSR strobes, flush and fetch redirect there.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter logic [CAUSE_WIDTH-1:0] IRQ_CAUSE      = IRQ_CAUSE_DEF,
  parameter int                     RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input logic              clock_i,
  input logic              reset_i,
  trap_controller_if.slave bus
);

  localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);

  pending_trap_t decode_raise_s, execute_raise_s, memory_raise_s;
  pending_trap_t pend_e_s, pend_m_s, pend_w_s;

  trap_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                   ctrl_reset_s;
  logic [CAUSE_WIDTH-1:0] mcause_s;
  logic                   mcause_irq_s;
  logic [XLEN-1:0]        mtval_s;
  logic                   mret_s;
  logic                   retire_s;
  logic                   flush_s;
  logic                   redirect_valid_s;
  logic [XLEN-1:0]        redirect_pc_s;

  assign decode_raise_s  = make_pending(bus.decodeTrap,  bus.decodeCause,  bus.decodeTval);
  assign execute_raise_s = make_pending(bus.executeTrap, bus.executeCause, bus.executeTval);
  assign memory_raise_s  = make_pending(bus.memoryTrap,  bus.memoryCause,  bus.memoryTval);

  trap_pending_stage u_pend_e (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .clear_i         (flush_s),
    .advance_in_i    (bus.advanceDE),
    .advance_out_i   (bus.advanceEM),
    .upstream_i      (NO_PENDING),
    .upstream_raise_i(decode_raise_s),
    .local_raise_i   (execute_raise_s),
    .pend_o          (pend_e_s)
  );

  trap_pending_stage u_pend_m (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .clear_i         (flush_s),
    .advance_in_i    (bus.advanceEM),
    .advance_out_i   (bus.advanceMW),
    .upstream_i      (pend_e_s),
    .upstream_raise_i(execute_raise_s),
    .local_raise_i   (memory_raise_s),
    .pend_o          (pend_m_s)
  );

  // Writeback never hands its record onward; it is replaced on advance or cleared by flush.
  trap_pending_stage u_pend_w (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .clear_i         (flush_s),
    .advance_in_i    (bus.advanceMW),
    .advance_out_i   (1'b0),
    .upstream_i      (pend_m_s),
    .upstream_raise_i(memory_raise_s),
    .local_raise_i   (NO_PENDING),
    .pend_o          (pend_w_s)
  );

  // Commit decision in writeback: exception > interrupt > MRET > retire; outputs quiet in reset.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    ctrl_reset_s     = 1'b0;
    mcause_s         = '0;
    mcause_irq_s     = 1'b0;
    mtval_s          = '0;
    mret_s           = 1'b0;
    retire_s         = 1'b0;
    flush_s          = 1'b0;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = '0;
    if (reset_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.writebackValid && pend_w_s.valid) begin
            ctrl_reset_s     = 1'b1;
            mcause_s         = pend_w_s.cause;
            mtval_s          = pend_w_s.tval;
            flush_s          = 1'b1;
            redirect_valid_s = 1'b1;
            redirect_pc_s    = bus.trapVector;
            state_d          = RECOVER;
            cnt_d            = CNT_W'(RECOVER_CYCLES);
          end else if (bus.writebackValid && bus.interrupt && bus.mie) begin
            ctrl_reset_s     = 1'b1;
            mcause_s         = IRQ_CAUSE;
            mcause_irq_s     = 1'b1;
            flush_s          = 1'b1;
            redirect_valid_s = 1'b1;
            redirect_pc_s    = bus.trapVector;
            state_d          = RECOVER;
            cnt_d            = CNT_W'(RECOVER_CYCLES);
          end else if (bus.writebackValid && bus.writebackMret) begin
            mret_s           = 1'b1;
            retire_s         = 1'b1;
            flush_s          = 1'b1;
            redirect_valid_s = 1'b1;
            redirect_pc_s    = bus.mepc;
            state_d          = RECOVER;
            cnt_d            = CNT_W'(RECOVER_CYCLES);
          end else begin
            retire_s = bus.writebackValid;
          end
        end
        RECOVER: begin
          flush_s = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and recovery counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.controlReset    = ctrl_reset_s;
  assign bus.mcause          = mcause_s;
  assign bus.mcauseInterrupt = mcause_irq_s;
  assign bus.mtval           = mtval_s;
  assign bus.mretSignal      = mret_s;
  assign bus.retireValid     = retire_s;
  assign bus.flush           = flush_s;
  assign bus.redirectValid   = redirect_valid_s;
  assign bus.redirectPC      = redirect_pc_s;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench: stimulus pushes the expected writeback response per cycle, a monitor compares.
module tb_trap_controller;
  import trap_controller_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  trap_controller_if bus ();

  trap_controller dut (
    .clock_i(clock),
    .reset_i(reset),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        cr;
    logic [3:0]  cause;
    logic        intr;
    logic [31:0] tval;
    logic        mret;
    logic        ret;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cyc_cnt = 32'd0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic push(input logic cr, input logic [3:0] cause, input logic intr,
                      input logic [31:0] tval, input logic mret, input logic ret,
                      input logic fl, input logic rv, input logic [31:0] rpc);
    exp_t e;
    e.cyc = cyc_cnt; e.cr = cr; e.cause = cause; e.intr = intr; e.tval = tval;
    e.mret = mret; e.ret = ret; e.flush = fl; e.rv = rv; e.rpc = rpc;
    sb.push_back(e);
  endtask

  task automatic exp_trap(input logic [3:0] cause, input logic [31:0] tval);
    push(1'b1, cause, 1'b0, tval, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
  endtask
  task automatic exp_irq();
    push(1'b1, 4'd11, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
  endtask
  task automatic exp_mret();
    push(1'b0, 4'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2040);
  endtask
  task automatic exp_retire();
    push(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic exp_flush();
    push(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic idle_inputs();
    bus.decodeTrap = 1'b0;  bus.decodeCause = 4'd0;  bus.decodeTval = 32'd0;
    bus.executeTrap = 1'b0; bus.executeCause = 4'd0; bus.executeTval = 32'd0;
    bus.memoryTrap = 1'b0;  bus.memoryCause = 4'd0;  bus.memoryTval = 32'd0;
    bus.advanceDE = 1'b0;   bus.advanceEM = 1'b0;    bus.advanceMW = 1'b0;
    bus.writebackValid = 1'b0; bus.writebackMret = 1'b0;
    bus.interrupt = 1'b0;   bus.mie = 1'b0;
  endtask

  task automatic adv_all();
    bus.advanceDE = 1'b1; bus.advanceEM = 1'b1; bus.advanceMW = 1'b1;
  endtask

  // Each new cycle starts just after the clock edge with quiet inputs.
  task automatic tick();
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  // Monitor: every cycle that shows a strobe, retire or flush must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.controlReset || bus.mretSignal || bus.retireValid || bus.flush || bus.redirectValid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: cycle=%0d controlReset=%0b mretSignal=%0b retireValid=%0b flush=%0b, required none",
                   cyc_cnt, bus.controlReset, bus.mretSignal, bus.retireValid, bus.flush);
        end else begin
          e = sb.pop_front();
          chk("event_cycle",     cyc_cnt,             e.cyc);
          chk("controlReset",    bus.controlReset,    e.cr);
          chk("mcause",          bus.mcause,          e.cause);
          chk("mcauseInterrupt", bus.mcauseInterrupt, e.intr);
          chk("mtval",           bus.mtval,           e.tval);
          chk("mretSignal",      bus.mretSignal,      e.mret);
          chk("retireValid",     bus.retireValid,     e.ret);
          chk("flush",           bus.flush,           e.flush);
          chk("redirectValid",   bus.redirectValid,   e.rv);
          chk("redirectPC",      bus.redirectPC,      e.rpc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.trapVector = 32'h0000_0100;
    bus.mepc       = 32'h0000_2040;
    // Outputs must stay quiet in reset even with a would-be interrupt commit.
    bus.writebackValid = 1'b1; bus.interrupt = 1'b1; bus.mie = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_controlReset",    bus.controlReset,    32'd0);
    chk("rst_mcause",          bus.mcause,          32'd0);
    chk("rst_mtval",           bus.mtval,           32'd0);
    chk("rst_mretSignal",      bus.mretSignal,      32'd0);
    chk("rst_retireValid",     bus.retireValid,     32'd0);
    chk("rst_flush",           bus.flush,           32'd0);
    chk("rst_redirectValid",   bus.redirectValid,   32'd0);
    chk("rst_redirectPC",      bus.redirectPC,      32'd0);
    tick(); reset = 1'b0;

    // Illegal instruction raised in decode reaches writeback three cycles later.
    bus.decodeTrap = 1'b1; bus.decodeCause = ILLEGAL_INSTR; bus.decodeTval = 32'h0000_FFFF; adv_all();
    tick(); adv_all();
    tick(); adv_all();
    tick(); adv_all(); bus.writebackValid = 1'b1; exp_trap(4'd2, 32'h0000_FFFF);
    tick(); exp_flush();
    tick();

    // Oldest raise wins: decode cause 0 beats later execute and memory raises.
    bus.decodeTrap = 1'b1; bus.decodeCause = INSTR_MISALIGNED; bus.decodeTval = 32'h0000_1000; adv_all();
    tick(); adv_all(); bus.executeTrap = 1'b1; bus.executeCause = BREAKPOINT; bus.executeTval = 32'h0000_3333;
    tick(); adv_all(); bus.memoryTrap = 1'b1; bus.memoryCause = LOAD_MISALIGNED; bus.memoryTval = 32'h0000_2000;
    tick(); bus.writebackValid = 1'b1; exp_trap(4'd0, 32'h0000_1000);
    tick(); exp_flush();
    tick();

    // Record held in M while advanceMW is low; exception also outranks a pending interrupt.
    bus.executeTrap = 1'b1; bus.executeCause = STORE_MISALIGNED; bus.executeTval = 32'h0000_0044; adv_all();
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.memoryTrap = 1'b1; bus.memoryCause = LOAD_MISALIGNED; bus.memoryTval = 32'h0000_0099;
    end
    tick(); bus.advanceMW = 1'b1;
    tick(); bus.writebackValid = 1'b1; bus.interrupt = 1'b1; bus.mie = 1'b1; exp_trap(4'd6, 32'h0000_0044);
    tick(); exp_flush();
    tick();

    // Empty stalled M absorbs a memory raise in place.
    bus.memoryTrap = 1'b1; bus.memoryCause = LOAD_MISALIGNED; bus.memoryTval = 32'h0000_0088;
    tick(); bus.advanceMW = 1'b1;
    tick(); bus.writebackValid = 1'b1; exp_trap(4'd4, 32'h0000_0088);
    tick(); exp_flush();
    tick();

    // Plain retire, then MRET.
    bus.writebackValid = 1'b1; exp_retire();
    tick(); bus.writebackValid = 1'b1; bus.writebackMret = 1'b1; exp_mret();
    tick(); exp_flush();
    tick(); bus.writebackValid = 1'b1; exp_retire();
    tick();

    // Interrupt taken with mie, ignored without; interrupt beats MRET.
    bus.writebackValid = 1'b1; bus.interrupt = 1'b1; bus.mie = 1'b1; exp_irq();
    tick(); bus.interrupt = 1'b1; bus.mie = 1'b1; exp_flush();
    tick(); bus.writebackValid = 1'b1; bus.interrupt = 1'b1; exp_retire();
    tick(); bus.writebackValid = 1'b1; bus.writebackMret = 1'b1; bus.interrupt = 1'b1; bus.mie = 1'b1; exp_irq();
    tick(); exp_flush();
    tick();

    // Reset inside RECOVER aborts it; reset also drops a stale decode record.
    bus.writebackValid = 1'b1; bus.interrupt = 1'b1; bus.mie = 1'b1; exp_irq();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    bus.decodeTrap = 1'b1; bus.decodeCause = ILLEGAL_INSTR; bus.decodeTval = 32'h0000_0BAD; bus.advanceDE = 1'b1;
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; bus.advanceEM = 1'b1;
    tick(); bus.advanceMW = 1'b1;
    tick(); bus.writebackValid = 1'b1; exp_retire();
    tick();
    tick();

    @(negedge clock);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
